// File: rtl/stopwatch_counter.sv
// Stopwatch time base: prescales clk to a centisecond tick and counts min:sec:csec under a 2-bit mode.
// Optional lap capture registers are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
  parameter int CLK_DIV = 500000,
  parameter int MIN_W   = 7,
  parameter int MAX_MIN = 99
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       en,
  input  logic             lap,
  output logic [6:0]       csec,
  output logic [5:0]       sec,
  output logic [MIN_W-1:0] min,
  output logic             tick,
  output logic             running,
  output logic             ovf,
  output logic [6:0]       lap_csec,
  output logic [5:0]       lap_sec,
  output logic [MIN_W-1:0] lap_min,
  output logic             lap_valid,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             clear;
  logic             advance;
  logic             tick_due;
  logic             at_max;

  // Handshake-free control: en is a level sampled every edge; en==00 overrides every state.
  assign clear    = (en == 2'b00);
  assign advance  = (state == RUN) && (en == 2'b01);
  assign tick_due = advance && (div_cnt == DIV_LAST);
  assign at_max   = (csec == 7'd99) && (sec == 6'd59) && (min == MIN_LAST);

  assign running   = (state == RUN);
  assign ovf       = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (en == 2'b01) state_next = RUN;
      RUN: begin
        if (en[1])                 state_next = PAUSE;
        else if (tick_due && at_max) state_next = DONE;
      end
      PAUSE:   if (en == 2'b01) state_next = RUN;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Prescaler and cascade; the saturating tick is swallowed so tick never shows outside RUN.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
      csec    <= '0;
      sec     <= '0;
      min     <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (advance) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!at_max) begin
            tick <= 1'b1;
            if (csec == 7'd99) begin
              csec <= '0;
              if (sec == 6'd59) begin
                sec <= '0;
                min <= min + 1'b1;
              end else begin
                sec <= sec + 1'b1;
              end
            end else begin
              csec <= csec + 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Capture uses the pre-edge count, so a coincident tick is not included.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_csec  <= '0;
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= 1'b0;
      if (lap && (state != IDLE)) begin
        lap_csec  <= csec;
        lap_sec   <= sec;
        lap_min   <= min;
        lap_valid <= 1'b1;
      end
    end
  end
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_csec   = '0;
  assign lap_sec    = '0;
  assign lap_min    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios with literal expectations plus
// randomized mode/lap/reset traffic, all compared every cycle against a centisecond-total model.
module tb_stopwatch_counter;

  localparam int CLK_DIV   = 4;
  localparam int MIN_W     = 7;
  localparam int MAX_MIN   = 1;
  localparam int MAX_TOTAL = (MAX_MIN + 1) * 6000 - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       en = 2'b00;
  logic             lap = 1'b0;
  logic [6:0]       csec;
  logic [5:0]       sec;
  logic [MIN_W-1:0] min;
  logic             tick;
  logic             running;
  logic             ovf;
  logic [6:0]       lap_csec;
  logic [5:0]       lap_sec;
  logic [MIN_W-1:0] lap_min;
  logic             lap_valid;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_DIV(CLK_DIV), .MIN_W(MIN_W), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .reset(reset), .en(en), .lap(lap),
    .csec(csec), .sec(sec), .min(min), .tick(tick),
    .running(running), .ovf(ovf),
    .lap_csec(lap_csec), .lap_sec(lap_sec), .lap_min(lap_min), .lap_valid(lap_valid),
    .state_dbg(state_dbg)
  );

  // ---------------- behavioural model: elapsed time as one integer ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_total = 0;      // elapsed centiseconds
  int    m_runs = 0;       // counted RUN cycles since last clear
  bit    m_tick = 0;
  int    m_lap_total = 0;
  bit    m_lap_valid = 0;

  always @(posedge clk) begin
    m_tick = 0;
    m_lap_valid = 0;
    if (reset || en == 2'b00) begin
      m_mode = M_IDLE;
      m_total = 0;
      m_runs = 0;
      m_lap_total = 0;
    end else begin
      if (lap && m_mode != M_IDLE) begin
        m_lap_total = m_total;
        m_lap_valid = 1;
      end
      case (m_mode)
        M_IDLE:  if (en == 2'b01) m_mode = M_RUN;
        M_PAUSE: if (en == 2'b01) m_mode = M_RUN;
        M_RUN: begin
          if (en != 2'b01) m_mode = M_PAUSE;
          else begin
            m_runs++;
            if (m_runs % CLK_DIV == 0) begin
              if (m_total == MAX_TOTAL) m_mode = M_DONE;
              else begin
                m_total++;
                m_tick = 1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(posedge clk) begin
    int exp_lap;
    #1;
    chk("csec", int'(csec), m_total % 100);
    chk("sec", int'(sec), (m_total / 100) % 60);
    chk("min", int'(min), m_total / 6000);
    chk("tick", int'(tick), int'(m_tick));
    chk("running", int'(running), int'(m_mode == M_RUN));
    chk("ovf", int'(ovf), int'(m_mode == M_DONE));
`ifdef STOPWATCH_LAP_EN
    exp_lap = m_lap_total;
    chk("lap_valid", int'(lap_valid), int'(m_lap_valid));
`else
    exp_lap = 0;
    chk("lap_valid", int'(lap_valid), 0);
`endif
    chk("lap_csec", int'(lap_csec), exp_lap % 100);
    chk("lap_sec", int'(lap_sec), (exp_lap / 100) % 60);
    chk("lap_min", int'(lap_min), exp_lap / 6000);
  end

  // ---------------- driver helpers ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_time(input string name, input int m, input int s, input int c);
    chk({name, "_min"}, int'(min), m);
    chk({name, "_sec"}, int'(sec), s);
    chk({name, "_csec"}, int'(csec), c);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // 1. reset, then run
    edges(2);
    chk_time("reset", 0, 0, 0);
    chk("reset_running", int'(running), 0);
    chk("reset_ovf", int'(ovf), 0);
    reset = 1'b0;
    en = 2'b01;
    edges(4);
    chk("pre_first_tick", int'(tick), 0);
    edges(1);
    chk("first_tick", int'(tick), 1);
    chk("first_tick_csec", int'(csec), 1);
    edges(396);
    chk_time("run400", 0, 1, 0);
    chk("run400_running", int'(running), 1);

    // 2. pause / resume phase retention
    en = 2'b00;
    edges(1);
    chk_time("clear", 0, 0, 0);
    en = 2'b01;
    edges(3);
    en = 2'b10;
    edges(10);
    chk_time("paused", 0, 0, 0);
    chk("paused_running", int'(running), 0);
    en = 2'b01;
    edges(2);
    chk("resume_no_tick", int'(tick), 0);
    edges(1);
    chk("resume_tick", int'(tick), 1);
    chk("resume_csec", int'(csec), 1);

    // 3./4. wraps and saturation
    en = 2'b00;
    edges(1);
    en = 2'b01;
    edges(1 + 4 * 99);
    chk_time("at_99", 0, 0, 99);
    edges(4);
    chk_time("wrap_sec", 0, 1, 0);
    edges(4 * (5999 - 100));
    chk_time("at_59_99", 0, 59, 99);
    edges(4);
    chk_time("wrap_min", 1, 0, 0);
    edges(4 * (MAX_TOTAL - 6000));
    chk_time("at_max", 1, 59, 99);
    chk("at_max_ovf", int'(ovf), 0);
    edges(4);
    chk_time("saturated", 1, 59, 99);
    chk("sat_ovf", int'(ovf), 1);
    chk("sat_running", int'(running), 0);
    chk("sat_tick", int'(tick), 0);
    en = 2'b10;
    edges(3);
    chk("sat_pause_ovf", int'(ovf), 1);
    en = 2'b01;
    edges(8);
    chk("sat_run_ovf", int'(ovf), 1);
    chk_time("sat_hold", 1, 59, 99);
    en = 2'b00;
    edges(1);
    chk_time("sat_clear", 0, 0, 0);
    chk("sat_clear_ovf", int'(ovf), 0);

    // 5. reset mid-count and clear on a tick edge
    en = 2'b01;
    edges(1 + 4 * 1234);
    chk_time("at_12_34", 0, 12, 34);
    reset = 1'b1;
    edges(1);
    chk_time("mid_reset", 0, 0, 0);
    chk("mid_reset_running", int'(running), 0);
    reset = 1'b0;
    edges(4);
    en = 2'b00;
    edges(1);
    chk_time("clear_on_tick", 0, 0, 0);
    chk("clear_on_tick_tick", int'(tick), 0);

    // 6. lap capture
    en = 2'b01;
    edges(1 + 4 * 307);
    chk_time("at_3_07", 0, 3, 7);
    lap = 1'b1;
    edges(1);
    lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    chk("lap_pulse", int'(lap_valid), 1);
    chk("lap_csec_val", int'(lap_csec), 7);
    chk("lap_sec_val", int'(lap_sec), 3);
`else
    chk("lap_pulse", int'(lap_valid), 0);
    chk("lap_csec_val", int'(lap_csec), 0);
    chk("lap_sec_val", int'(lap_sec), 0);
`endif
    edges(1);
    chk("lap_pulse_end", int'(lap_valid), 0);
    chk("lap_keeps_counting", int'(running), 1);
    lap = 1'b1;
    en = 2'b00;
    edges(1);
    chk("lap_with_clear_valid", int'(lap_valid), 0);
    chk("lap_with_clear_csec", int'(lap_csec), 0);
    lap = 1'b0;

    // randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      en = 2'b01;
      else if (r < 85) en = 2'b10;
      else if (r < 93) en = 2'b11;
      else             en = 2'b00;
      lap   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 299) == 0);
      edges(1);
    end
    reset = 1'b0;
    en = 2'b00;
    lap = 1'b0;
    edges(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
